mem_wb_skid: RTL
================

MEM_WB_SKID -- requirements
Module: mem_wb_skid

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning data/result width in bits.
REQ-002 The block SHALL have parameter REG_AW, default 5, meaning destination-register index width.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 The block SHALL have port flush  input  1  discard all held and incoming entries.
REQ-006 The block SHALL have port in_valid  input  1  MEM-stage entry present.
REQ-007 The block SHALL have port in_ready  output  1  block can accept an entry this cycle.
REQ-008 The block SHALL have ports in_read_data, in_alu_result  input  XLEN  load data and ALU result.
REQ-009 The block SHALL have port in_rd  input  REG_AW  destination register.
REQ-010 The block SHALL have ports in_reg_write, in_mem_to_reg  input  1  control bits.
REQ-011 The block SHALL have port out_valid  output  1  WB entry present.
REQ-012 The block SHALL have port out_ready  input  1  WB consumes the entry this cycle.
REQ-013 The block SHALL have ports out_wb_data  output  XLEN, out_rd  output  REG_AW, out_reg_write  output  1.

Function
REQ-014 Transfers SHALL occur on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-015 Storage SHALL be two entries: main (drives outputs) and skid; in_ready SHALL equal !skid_valid, a registered value with no combinational path from out_ready.
REQ-016 On input transfer with main empty or main consumed this cycle and skid empty, the entry SHALL load main; latency in->out SHALL be 1 cycle.
REQ-017 On input transfer while main is held (out_valid&&!out_ready), the entry SHALL load skid.
REQ-018 When main is consumed and skid is valid, skid SHALL move to main and skid_valid SHALL clear in that same edge; any input accepted that cycle SHALL load skid.
REQ-019 out_wb_data SHALL be registered as in_mem_to_reg ? in_read_data : in_alu_result at capture.
REQ-020 out_reg_write SHALL be 0 when the captured rd equals 0, else the captured in_reg_write.
REQ-021 Outputs SHALL remain stable while out_valid&&!out_ready.
REQ-022 Order SHALL be preserved; no entry SHALL be dropped or duplicated except by flush.
REQ-023 flush SHALL clear main and skid valid at the next edge, discard any same-cycle input, and take priority over all transfers.

Reset
REQ-024 With rst_n low at a rising edge: out_valid, skid_valid, out_wb_data, out_rd, out_reg_write SHALL become 0.
REQ-025 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-026 Reset mid-operation SHALL discard both entries with no partial output.

Configuration
REQ-027 With MEM_WB_STALL_CNT_EN defined, port stall_cnt (output, 32) SHALL count cycles with out_valid&&!out_ready, saturate at 0xFFFFFFFF, and reset to 0.
REQ-028 Without MEM_WB_STALL_CNT_EN, the stall_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package mem_wb_pkg SHALL hold XLEN/REG_AW defaults and the packed payload typedef (wb_data, rd, reg_write).
REQ-030 The two-entry buffer SHALL be sub-module pipe_skid, parametrised on payload width; mem_wb_skid adds the mux, rd==0 gating and counter.

Verification
REQ-031 Single entry: in_valid=1, alu=0x1234, mem_to_reg=0, rd=3, reg_write=1, out_ready=1 -> next cycle out_valid=1, out_wb_data=0x1234, out_rd=3.
REQ-032 Stall: out_ready=0, push A then B -> A held on outputs, in_ready=0 after B; out_ready=1 -> A then B on consecutive cycles, in_ready=1 again.
REQ-033 rd=0 with reg_write=1, read_data=0xDEAD, mem_to_reg=1 -> out_wb_data=0xDEAD, out_reg_write=0.
REQ-034 Both entries full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, input discarded.
REQ-035 rst_n=0 with both entries valid -> all outputs 0 next edge; in_ready=1 first cycle after release.
REQ-036 MEM_WB_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10; preset near max -> saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB skid stage: default widths, the
// write-back payload layout and the rd==0 write-enable gating rule.
package mem_wb_pkg;

   localparam int unsigned XLEN_DEFAULT   = 64;
   localparam int unsigned REG_AW_DEFAULT = 5;
   localparam int unsigned STALL_CNT_W    = 32;

   // Write-back payload at default widths; the top module re-declares the
   // same field order with its own parameter widths.
   typedef struct packed {
      logic [XLEN_DEFAULT-1:0]   wb_data;
      logic [REG_AW_DEFAULT-1:0] rd;
      logic                      reg_write;
   } wb_payload_t;

   // x0 is hard-wired, so a write to it is suppressed at capture.
   function automatic logic gate_reg_write(input logic rd_is_zero,
                                           input logic reg_write);
      return reg_write & ~rd_is_zero;
   endfunction

endpackage

// File: rtl/mem_wb_skid_pipe.sv
// pipe_skid: two-entry valid/ready buffer (main drives outputs, skid
// absorbs one entry while main is held). in_ready depends only on
// registered state and rst_n, never on out_ready.
module pipe_skid import mem_wb_pkg::*; #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             main_valid;
   logic             skid_valid;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic             in_fire;
   logic             main_free;

   assign in_ready  = rst_n & ~skid_valid;
   assign in_fire   = in_valid & in_ready;
   assign main_free = ~main_valid | out_ready;
   assign out_valid = main_valid;
   assign out_data  = main_data;

   // Entry movement: flush beats transfers; skid refills main before new input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         if (skid_valid) begin
            main_data  <= skid_data;
            main_valid <= 1'b1;
            skid_valid <= in_fire;
            if (in_fire) begin
               skid_data <= in_data;
            end
         end else begin
            main_valid <= in_fire;
            if (in_fire) begin
               main_data <= in_data;
            end
         end
      end else if (in_fire) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/mem_wb_skid.sv
// mem_wb_skid: MEM->WB pipeline register with skid buffering. Selects the
// write-back value and gates rd==0 writes at capture.
// Optional: define MEM_WB_STALL_CNT_EN to add the saturating stall_cnt port.
module mem_wb_skid import mem_wb_pkg::*; #(
   parameter int unsigned XLEN   = XLEN_DEFAULT,
   parameter int unsigned REG_AW = REG_AW_DEFAULT
) (
   input  logic                   clk,
`ifdef MEM_WB_STALL_CNT_EN
   output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [XLEN-1:0]        in_read_data,
   input  logic [XLEN-1:0]        in_alu_result,
   input  logic [REG_AW-1:0]      in_rd,
   input  logic                   in_reg_write,
   input  logic                   in_mem_to_reg,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [XLEN-1:0]        out_wb_data,
   output logic [REG_AW-1:0]      out_rd,
   output logic                   out_reg_write
);

   typedef struct packed {
      logic [XLEN-1:0]   wb_data;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
   } entry_t;

   entry_t in_entry;
   entry_t out_entry;

   // Build the captured payload: data mux and x0 write suppression.
   always_comb begin
      in_entry           = '0;
      in_entry.wb_data   = in_mem_to_reg ? in_read_data : in_alu_result;
      in_entry.rd        = in_rd;
      in_entry.reg_write = gate_reg_write(in_rd == '0, in_reg_write);
   end

   pipe_skid #(
      .WIDTH($bits(entry_t))
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_entry)
   );

   assign out_wb_data   = out_entry.wb_data;
   assign out_rd        = out_entry.rd;
   assign out_reg_write = out_entry.reg_write;

`ifdef MEM_WB_STALL_CNT_EN
   // Count cycles where WB holds a valid entry it cannot consume; saturates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule
